neander_uart_loader: RTL and testbench

Upstream feeder for the CPU+RAM memory load port. Receives a framed program image over an 8N1 UART line and writes it into RAM through the mem_load_en/mem_load_addr/mem_load_data interface. Holds the CPU in reset via cpu_hold until a complete, valid image has been loaded. Sits between the chip's serial input pin and the CPU/RAM top.

---
 rtl/neander_uart_loader.sv | 275 +++++++++++++++++++++++++++
 tb/tb_neander_uart_loader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/neander_uart_loader.sv
// UART (8N1) program loader: receives "A5 addr len data... [csum]" frames and writes them into RAM.
// Optional checksum byte and verification enabled by defining LOADER_CHECKSUM_EN.
module neander_uart_loader #(
    parameter int CLKS_PER_BIT   = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic       mem_load_en,
    output logic [7:0] mem_load_addr,
    output logic [7:0] mem_load_data,
    output logic       cpu_hold,
    output logic       load_done,
    output logic       load_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    SYNC_BYTE = 8'hA5;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    localparam logic [2:0] P_SYNC = 3'd0;
    localparam logic [2:0] P_ADDR = 3'd1;
    localparam logic [2:0] P_LEN  = 3'd2;
    localparam logic [2:0] P_DATA = 3'd3;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] P_CSUM = 3'd4;
`endif

    // ---------------- receiver ----------------
    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    logic [1:0]    r_state_q, r_state_d;
    logic [CW-1:0] r_cnt_q, r_cnt_d;
    logic [2:0]    r_bit_q, r_bit_d;
    logic [7:0]    r_shift_q, r_shift_d;
    logic          byte_valid_q, byte_valid_d;
    logic          frame_err_q, frame_err_d;

    always_comb begin
        r_state_d    = r_state_q;
        r_cnt_d      = r_cnt_q;
        r_bit_d      = r_bit_q;
        r_shift_d    = r_shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                r_cnt_d = '0;
                if (rx_prev_q && !rx_s2_q) r_state_d = R_START;
            end
            R_START: begin
                if (r_cnt_q == HALF) begin
                    // A start bit that is high again at mid-bit is a glitch.
                    r_cnt_d   = '0;
                    r_bit_d   = '0;
                    r_state_d = rx_s2_q ? R_IDLE : R_DATA;
                end else begin
                    r_cnt_d = r_cnt_q + 1'b1;
                end
            end
            R_DATA: begin
                if (r_cnt_q == FULL) begin
                    r_cnt_d   = '0;
                    r_shift_d = {rx_s2_q, r_shift_q[7:1]};
                    r_bit_d   = r_bit_q + 1'b1;
                    if (r_bit_q == 3'd7) r_state_d = R_STOP;
                end else begin
                    r_cnt_d = r_cnt_q + 1'b1;
                end
            end
            R_STOP: begin
                if (r_cnt_q == FULL) begin
                    r_state_d    = R_IDLE;
                    byte_valid_d = rx_s2_q;
                    frame_err_d  = !rx_s2_q;
                end else begin
                    r_cnt_d = r_cnt_q + 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
            r_state_q    <= R_IDLE;
            r_cnt_q      <= '0;
            r_bit_q      <= '0;
            r_shift_q    <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_s1_q      <= uart_rx;
            rx_s2_q      <= rx_s1_q;
            rx_prev_q    <= rx_s2_q;
            r_state_q    <= r_state_d;
            r_cnt_q      <= r_cnt_d;
            r_bit_q      <= r_bit_d;
            r_shift_q    <= r_shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // ---------------- frame protocol ----------------
    // r_shift_q is stable from the stop sample until the next frame's first data bit.
    logic [7:0]    rx_byte;
    logic [2:0]    p_state_q, p_state_d;
    logic [7:0]    addr_q, addr_d;
    logic [8:0]    rem_q, rem_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          wr_en_q, wr_en_d;
    logic [7:0]    wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          hold_q, hold_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    sum_q, sum_d;
`else
    logic          pend_q, pend_d;
`endif

    assign rx_byte = r_shift_q;

    always_comb begin
        p_state_d = p_state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        hold_d    = hold_q;
        done_d    = done_q;
        err_d     = err_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d     = sum_q;
`else
        pend_d    = 1'b0;
`endif
        if (p_state_q == P_SYNC || byte_valid_q) timer_d = '0;
        else                                     timer_d = timer_q + 1'b1;

        case (p_state_q)
            P_SYNC: begin
                if (byte_valid_q && rx_byte == SYNC_BYTE) begin
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    hold_d    = 1'b1;
                    p_state_d = P_ADDR;
                end
            end
            P_ADDR: begin
                if (byte_valid_q) begin
                    addr_d    = rx_byte;
                    p_state_d = P_LEN;
                end
            end
            P_LEN: begin
                if (byte_valid_q) begin
                    rem_d     = (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
`ifdef LOADER_CHECKSUM_EN
                    sum_d     = '0;
`endif
                    p_state_d = P_DATA;
                end
            end
            P_DATA: begin
                if (byte_valid_q) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = rx_byte;
                    addr_d    = addr_q + 1'b1;
                    rem_d     = rem_q - 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d     = sum_q + rx_byte;
                    if (rem_q == 9'd1) p_state_d = P_CSUM;
`else
                    if (rem_q == 9'd1) begin
                        p_state_d = P_SYNC;
                        pend_d    = 1'b1;
                    end
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            P_CSUM: begin
                if (byte_valid_q) begin
                    if (rx_byte == sum_q) begin
                        done_d = 1'b1;
                        hold_d = 1'b0;
                    end else begin
                        err_d  = 1'b1;
                    end
                    p_state_d = P_SYNC;
                end
            end
`endif
            default: p_state_d = P_SYNC;
        endcase

        // Aborts only apply mid-frame; bytes already written are left in RAM.
        if (p_state_q != P_SYNC && (frame_err_q || timer_q == TMAX)) begin
            err_d     = 1'b1;
            done_d    = 1'b0;
            hold_d    = 1'b1;
            p_state_d = P_SYNC;
        end

`ifndef LOADER_CHECKSUM_EN
        // Release the CPU the cycle after the final write strobe.
        if (pend_q) begin
            done_d = 1'b1;
            hold_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            p_state_q <= P_SYNC;
            addr_q    <= '0;
            rem_q     <= '0;
            timer_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            hold_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q     <= '0;
`else
            pend_q    <= 1'b0;
`endif
        end else begin
            p_state_q <= p_state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            timer_q   <= timer_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q     <= sum_d;
`else
            pend_q    <= pend_d;
`endif
        end
    end

    assign mem_load_en   = wr_en_q;
    assign mem_load_addr = wr_addr_q;
    assign mem_load_data = wr_data_q;
    assign cpu_hold      = hold_q;
    assign load_done     = done_q;
    assign load_err      = err_q;
    assign busy          = (p_state_q != P_SYNC);

endmodule

// File: tb/tb_neander_uart_loader.sv
// Randomized bench for neander_uart_loader: frames are serialized onto uart_rx and the observed
// RAM writes and status flags are compared with a frame-level reference model.
module tb_neander_uart_loader;
    localparam int CPB = 4;
    localparam int TMO = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       uart_rx = 1'b1;
    logic       mem_load_en;
    logic [7:0] mem_load_addr, mem_load_data;
    logic       cpu_hold, load_done, load_err, busy;

    neander_uart_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .uart_rx(uart_rx),
        .mem_load_en(mem_load_en), .mem_load_addr(mem_load_addr), .mem_load_data(mem_load_data),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Observed write strobes, plus a count of strobes longer than one cycle.
    logic [15:0] wr_q[$];
    logic        en_prev = 1'b0;
    int          stretched = 0;
    always @(negedge clk) begin
        if (mem_load_en) wr_q.push_back({mem_load_addr, mem_load_data});
        if (mem_load_en && en_prev) stretched <= stretched + 1;
        en_prev <= mem_load_en;
    end

    // Reference model: expected writes and expected status after each frame.
    logic [15:0] exp_q[$];
    logic [7:0]  dq[$];
    logic        m_done = 1'b0, m_err = 1'b0, m_hold = 1'b1;

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic check_writes(input string tag);
        int n;
        chk({tag, "_nwr"}, wr_q.size(), exp_q.size());
        n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_wa"}, wr_q[i][15:8], exp_q[i][15:8]);
            chk({tag, "_wd"}, wr_q[i][7:0], exp_q[i][7:0]);
        end
        wr_q.delete();
        exp_q.delete();
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_done"}, load_done, m_done);
        chk({tag, "_err"}, load_err, m_err);
        chk({tag, "_hold"}, cpu_hold, m_hold);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_en"}, mem_load_en, 1'b0);
        chk({tag, "_addr"}, mem_load_addr, 8'h00);
        chk({tag, "_data"}, mem_load_data, 8'h00);
        chk({tag, "_hold"}, cpu_hold, 1'b1);
        chk({tag, "_done"}, load_done, 1'b0);
        chk({tag, "_err"}, load_err, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    // Sync + addr + len + payload from dq (+ checksum when enabled); bad_csum only matters with checksums.
    task automatic send_frame(input string tag, input logic [7:0] addr, input bit bad_csum);
        logic [7:0] a, sum, len;
        len = 8'(dq.size());
        send_byte(8'hA5, 1'b1);
        repeat (3) @(negedge clk);
        chk({tag, "_sync_hold"}, cpu_hold, 1'b1);
        chk({tag, "_sync_flags"}, {load_done, load_err}, 2'b00);
        chk({tag, "_sync_busy"}, busy, 1'b1);
        send_byte(addr, 1'b1);
        send_byte(len, 1'b1);
        a = addr;
        sum = 8'h00;
        foreach (dq[i]) begin
            send_byte(dq[i], 1'b1);
            exp_q.push_back({a, dq[i]});
            a = a + 8'd1;
            sum = sum + dq[i];
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(bad_csum ? sum + 8'd1 : sum, 1'b1);
        m_done = !bad_csum;
        m_err  = bad_csum;
        m_hold = bad_csum;
`else
        m_done = 1'b1;
        m_err  = 1'b0;
        m_hold = 1'b0;
`endif
        repeat (8) @(negedge clk);
        check_writes(tag);
        check_flags(tag);
    endtask

    initial begin
        logic [7:0] g;
        int len;

        repeat (4) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b1;
        repeat (1000) @(negedge clk);
        chk("idle_nwr", wr_q.size(), 0);
        check_flags("idle");

        dq = '{8'h11, 8'h22, 8'h33};
        send_frame("basic", 8'h10, 1'b0);

        dq = '{8'h01, 8'h02, 8'h03};
        send_frame("wrap", 8'hFE, 1'b0);

        dq = '{8'h55};
        send_frame("badsum", 8'h20, 1'b1);
        dq = '{8'h99, 8'h88};
        send_frame("recover", 8'h21, 1'b0);

        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h5A, 1'b1);
        repeat (4) @(negedge clk);
        chk("garbage_busy", busy, 1'b0);
        dq = '{8'h7E};
        send_frame("garbage", 8'h30, 1'b0);

        // Stop bit forced low mid-frame.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h60, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h11, 1'b1);
        exp_q.push_back({8'h60, 8'h11});
        send_byte(8'h22, 1'b0);
        m_done = 1'b0; m_err = 1'b1; m_hold = 1'b1;
        repeat (8) @(negedge clk);
        check_writes("framing");
        check_flags("framing");

        // Line goes idle after the length byte.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h40, 1'b1);
        send_byte(8'h02, 1'b1);
        repeat (50) @(negedge clk);
        chk("tmo_early_err", load_err, 1'b0);
        chk("tmo_early_busy", busy, 1'b1);
        repeat (70) @(negedge clk);
        check_writes("tmo");
        check_flags("tmo");

        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'hA5) g = 8'h00;
                send_byte(g, 1'b1);
            end
            len = (it == 3) ? 256 : $urandom_range(1, 6);
            dq.delete();
            for (int k = 0; k < len; k++) dq.push_back(8'($urandom_range(0, 255)));
            send_frame("rand", 8'($urandom_range(0, 255)), $urandom_range(0, 3) == 0);
        end

        // Reset after the first of three data bytes.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h50, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'hAA, 1'b1);
        exp_q.push_back({8'h50, 8'hAA});
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("midrst");
        reset = 1'b1;
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        repeat (10) @(negedge clk);
        m_done = 1'b0; m_err = 1'b0; m_hold = 1'b1;
        check_writes("midrst");
        check_flags("midrst");

        chk("strobe_width", stretched, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
